// File: rtl/text_writer_pkg.sv
// rtl/text_writer_pkg.sv - shared constants for the character tile RAM writer
// Control codes, FSM encoding and default screen geometry.
package text_writer_pkg;

    localparam int TW_COLS   = 40;
    localparam int TW_ROWS   = 30;
    localparam int TW_ADDR_W = 11;

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_DEL   = 8'h7F;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WRITE    = 2'd1;
    localparam logic [1:0] CLR_LINE = 2'd2;
    localparam logic [1:0] CLR_ALL  = 2'd3;

    // Codes below space and DEL are control codes; everything else prints.
    function automatic logic is_printable(input logic [7:0] b);
        return (b >= CH_SPACE) && (b != CH_DEL);
    endfunction

endpackage

// File: rtl/text_writer.sv
// rtl/text_writer.sv - byte stream to tile RAM write sequencer with text cursor
// Write outputs are registered from next-state values so each write lines up with its state.
module text_writer
    import text_writer_pkg::*;
#(
    parameter int         COLS   = TW_COLS,
    parameter int         ROWS   = TW_ROWS,
    parameter int         ADDR_W = TW_ADDR_W,
    parameter logic [7:0] FILL   = CH_SPACE
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [5:0]        cur_x,
    output logic [4:0]        cur_y,
    output logic              busy
);

    localparam int CELLS = COLS * ROWS;
    localparam int CNT_W = $clog2(CELLS + 1);

    localparam logic [5:0]        X_LAST = 6'(COLS - 1);
    localparam logic [4:0]        Y_LAST = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] A_COLS = ADDR_W'(COLS);
    localparam logic [CNT_W-1:0]  N_LINE = CNT_W'(COLS);
    localparam logic [CNT_W-1:0]  N_ALL  = CNT_W'(CELLS);

    generate
        if (CELLS > (1 << ADDR_W)) begin : g_bad_geometry
            $error("text_writer: COLS*ROWS does not fit in ADDR_W address bits");
        end
    endgenerate

    logic [1:0]        r_state, w_state;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic [5:0]        r_x, w_x;
    logic [4:0]        r_y, w_y;
    logic [ADDR_W-1:0] r_row_base, w_row_base;
    logic              r_adv, w_adv;
    logic              r_wr_en, w_wr_en;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr;
    logic [7:0]        r_wr_data, w_wr_data;
    logic              w_line_start;
    logic [4:0]        w_next_y;
    logic [ADDR_W-1:0] w_next_base;

    // Line advance without a multiplier: row_base tracks cur_y*COLS.
    assign w_next_y    = (r_y == Y_LAST) ? '0 : r_y + 5'd1;
    assign w_next_base = (r_y == Y_LAST) ? '0 : r_row_base + A_COLS;

    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_x          = r_x;
        w_y          = r_y;
        w_row_base   = r_row_base;
        w_adv        = r_adv;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_wr_addr;
        w_wr_data    = r_wr_data;
        w_line_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    case (in_data)
                        CH_LF: begin
                            w_x          = '0;
                            w_y          = w_next_y;
                            w_row_base   = w_next_base;
                            w_line_start = 1'b1;
                        end
                        CH_CR: w_x = '0;
                        CH_BS: begin
                            if (r_x != '0) begin
                                w_x       = r_x - 6'd1;
                                w_adv     = 1'b0;
                                w_state   = WRITE;
                                w_wr_en   = 1'b1;
                                w_wr_addr = r_row_base + ADDR_W'(r_x - 6'd1);
                                w_wr_data = FILL;
                            end
                        end
                        CH_FF: begin
                            w_state   = CLR_ALL;
                            w_cnt     = CNT_W'(1);
                            w_wr_en   = 1'b1;
                            w_wr_addr = '0;
                            w_wr_data = FILL;
                        end
                        default: begin
                            if (is_printable(in_data)) begin
                                w_adv     = 1'b1;
                                w_state   = WRITE;
                                w_wr_en   = 1'b1;
                                w_wr_addr = r_row_base + ADDR_W'(r_x);
                                w_wr_data = in_data;
                            end
                        end
                    endcase
                end
            end
            WRITE: begin
                if (!r_adv) begin
                    w_state = IDLE;
                end else if (r_x != X_LAST) begin
                    w_x     = r_x + 6'd1;
                    w_state = IDLE;
                end else begin
                    w_x          = '0;
                    w_y          = w_next_y;
                    w_row_base   = w_next_base;
                    w_line_start = 1'b1;
                end
            end
            CLR_LINE: begin
                if (r_cnt == N_LINE) begin
                    w_state = IDLE;
                end else begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_row_base + ADDR_W'(r_cnt);
                    w_wr_data = FILL;
                    w_cnt     = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                if (r_cnt == N_ALL) begin
                    w_state    = IDLE;
                    w_x        = '0;
                    w_y        = '0;
                    w_row_base = '0;
                end else begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = ADDR_W'(r_cnt);
                    w_wr_data = FILL;
                    w_cnt     = r_cnt + CNT_W'(1);
                end
            end
        endcase
        // The first cell of a line clear is issued on the entry edge so the
        // CLR_LINE state and its COLS writes coincide cycle for cycle.
        if (w_line_start) begin
            w_state   = CLR_LINE;
            w_cnt     = CNT_W'(1);
            w_wr_en   = 1'b1;
            w_wr_addr = w_row_base;
            w_wr_data = FILL;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= CLR_ALL;
            r_cnt      <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_row_base <= '0;
            r_adv      <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_x        <= w_x;
            r_y        <= w_y;
            r_row_base <= w_row_base;
            r_adv      <= w_adv;
            r_wr_en    <= w_wr_en;
            r_wr_addr  <= w_wr_addr;
            r_wr_data  <= w_wr_data;
        end
    end

    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign cur_x    = r_x;
    assign cur_y    = r_y;

endmodule

// File: tb/tb_text_writer.sv
// tb/tb_text_writer.sv - self-checking bench for text_writer
// A screen model queues expected tile RAM writes; every observed write is popped and compared.
module tb_text_writer;

    logic        clk;
    logic        rstn;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic [5:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;

    text_writer dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cur_x    (cur_x),
        .cur_y    (cur_y),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         ex;
        int         ey;
    } vec_t;

    vec_t      vecs[16];
    bit [18:0] exp_q[$];
    int        checks = 0;
    int        errors = 0;
    int        mx, my;
    int        cyc, n_wr, run_first, run_last, n0;
    logic      s_ready, s_wr;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int a, input logic [7:0] d);
        exp_q.push_back({11'(a), d});
    endtask

    task automatic model_line_adv();
        my = (my == 29) ? 0 : my + 1;
        for (int k = 0; k < 40; k++) push(my * 40 + k, 8'h20);
    endtask

    task automatic model_clear_all();
        for (int i = 0; i < 1200; i++) push(i, 8'h20);
        mx = 0;
        my = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        case (b)
            8'h0A: begin mx = 0; model_line_adv(); end
            8'h0D: mx = 0;
            8'h08: if (mx > 0) begin mx--; push(my * 40 + mx, 8'h20); end
            8'h0C: model_clear_all();
            default: begin
                if (b >= 8'h20 && b != 8'h7F) begin
                    push(my * 40 + mx, b);
                    if (mx < 39) mx++;
                    else begin mx = 0; model_line_adv(); end
                end
            end
        endcase
    endtask

    // One clock: sample and score at the falling edge, return just after the rising edge.
    task automatic step();
        bit [18:0] e;
        @(negedge clk);
        s_ready = in_ready;
        s_wr    = wr_en;
        if (wr_en) begin
            n_wr++;
            if (run_first < 0) run_first = cyc;
            run_last = cyc;
            check_eq("busy_during_write", int'(busy), 1);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write_queue_size", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_eq($sformatf("write_addr@%0d", cyc), int'(wr_addr), int'(e[18:8]));
                check_eq($sformatf("write_data@%0d", cyc), int'(wr_data), int'(e[7:0]));
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        model_byte(b);
        in_data  = b;
        in_valid = 1'b1;
        do begin step(); n++; end while (!s_ready && n < 3000);
        check_eq("accept_timeout", int'(s_ready), 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin step(); n++; end while (!s_ready && n < 3000);
        check_eq("idle_timeout", int'(s_ready), 1);
    endtask

    task automatic check_cursor(input string name, input int ex, input int ey);
        check_eq({name, "_cur_x"}, int'(cur_x), ex);
        check_eq({name, "_cur_y"}, int'(cur_y), ey);
        check_eq({name, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic check_full_clear(input string name);
        check_eq({name, "_writes"}, n_wr - n0, 1200);
        check_eq({name, "_consecutive"}, run_last - run_first + 1, 1200);
        check_cursor(name, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{8'h07, 0, 1};
        vecs[1]  = '{8'h7F, 0, 1};
        vecs[2]  = '{8'h43, 1, 1};
        vecs[3]  = '{8'h08, 0, 1};
        vecs[4]  = '{8'h08, 0, 1};
        vecs[5]  = '{8'hC3, 1, 1};
        vecs[6]  = '{8'h1B, 1, 1};
        vecs[7]  = '{8'h0D, 0, 1};
        vecs[8]  = '{8'h0A, 0, 2};
        vecs[9]  = '{8'h41, 1, 2};
        vecs[10] = '{8'h41, 2, 2};
        vecs[11] = '{8'h41, 3, 2};
        vecs[12] = '{8'h08, 2, 2};
        vecs[13] = '{8'h0D, 0, 2};
        vecs[14] = '{8'h07, 0, 2};
        vecs[15] = '{8'h00, 0, 2};

        rstn = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        mx = 0; my = 0; cyc = 0; n_wr = 0; run_first = -1; run_last = -1;
        s_ready = 1'b0; s_wr = 1'b0;
        repeat (3) step();
        check_eq("reset_wr_en", int'(wr_en), 0);
        check_eq("reset_wr_addr", int'(wr_addr), 0);
        check_eq("reset_wr_data", int'(wr_data), 0);
        check_eq("reset_in_ready", int'(in_ready), 0);
        check_eq("reset_busy", int'(busy), 1);
        check_eq("reset_cur_x", int'(cur_x), 0);
        check_eq("reset_cur_y", int'(cur_y), 0);

        // Power-up blanking of the whole screen.
        rstn = 1'b1;
        n0 = n_wr; run_first = -1;
        model_clear_all();
        wait_idle();
        check_full_clear("init");

        // Single printable byte: write visible the cycle after acceptance.
        send(8'h41);
        step();
        check_eq("a_write_cycle_in_ready", int'(s_ready), 0);
        check_eq("a_write_cycle_wr_en", int'(s_wr), 1);
        step();
        check_eq("a_after_in_ready", int'(s_ready), 1);
        check_cursor("a_after", 1, 0);

        send(8'h0D);
        wait_idle();
        check_cursor("cr_home", 0, 0);

        // A full row of characters wraps and clears the next row.
        for (int i = 0; i < 40; i++) send(8'h42);
        wait_idle();
        check_cursor("row_fill", 0, 1);

        for (int i = 0; i < 16; i++) begin
            send(vecs[i].b);
            wait_idle();
            check_cursor($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey);
        end

        // LF from the last row wraps to row 0 and clears it.
        for (int i = 0; i < 27; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h45);
        wait_idle();
        check_cursor("pos_5_29", 5, 29);
        send(8'h0A);
        wait_idle();
        check_cursor("lf_wrap", 0, 0);
        n0 = n_wr;
        send(8'h08);
        wait_idle();
        check_eq("bs_at_col0_writes", n_wr - n0, 0);
        check_cursor("bs_at_col0", 0, 0);

        // Printable byte in the bottom-right cell.
        for (int i = 0; i < 29; i++) send(8'h0A);
        for (int i = 0; i < 39; i++) send(8'h46);
        wait_idle();
        check_cursor("pos_39_29", 39, 29);
        send(8'h47);
        wait_idle();
        check_cursor("last_cell_wrap", 0, 0);

        // Byte offered while busy must wait until the line clear ends.
        send(8'h0A);
        send(8'h48);
        wait_idle();
        check_cursor("backpressure", 1, 1);

        // Reset in the middle of a full clear restarts it from address 0.
        send(8'h0C);
        n0 = n_wr;
        begin
            int n = 0;
            while (n_wr - n0 < 500 && n < 3000) begin step(); n++; end
            check_eq("ff_progress_writes", n_wr - n0, 500);
        end
        rstn = 1'b0;
        #1;
        check_eq("midclr_rst_wr_en", int'(wr_en), 0);
        check_eq("midclr_rst_busy", int'(busy), 1);
        check_eq("midclr_rst_in_ready", int'(in_ready), 0);
        check_eq("midclr_rst_cur_x", int'(cur_x), 0);
        check_eq("midclr_rst_cur_y", int'(cur_y), 0);
        exp_q.delete();
        mx = 0; my = 0;
        repeat (3) step();
        rstn = 1'b1;
        n0 = n_wr; run_first = -1;
        model_clear_all();
        wait_idle();
        check_full_clear("reclear");
        send(8'h5A);
        wait_idle();
        check_cursor("post_reclear", 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/text_writer.md
Name: text_writer

Overview:
- Sequences all writes into the character tile RAM that feeds the font/VGA pixel pipeline.
- Accepts a byte stream (ASCII plus a few control codes) over a valid/ready handshake.
- Keeps a text cursor and turns each byte into tile RAM writes: character stores, line clears and full-screen clears.
- Sits between a host source (UART receiver, test pattern generator) and the tile RAM write port, in the write-clock domain (`clk`).

Parameters:
- COLS, 40, characters per row (640 px / 16 px at zoom 1).
- ROWS, 30, text rows (480 px / 16 px).
- ADDR_W, 11, tile RAM address width; must satisfy COLS*ROWS <= 2**ADDR_W (elaboration check).
- FILL, 8'h20, code written by every clear operation.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_data  in  8  byte to print or control code.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a byte this cycle; transfer happens when in_valid && in_ready.
- wr_en  out  1  tile RAM write strobe.
- wr_addr  out  ADDR_W  tile RAM write address = row*COLS + col.
- wr_data  out  8  tile RAM write data.
- cur_x  out  6  cursor column, 0..COLS-1.
- cur_y  out  5  cursor row, 0..ROWS-1.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=CLR_ALL, clear counter=0, cur_x=0, cur_y=0, row_base=0.
  - wr_en=0, wr_addr=0, wr_data=0.
  - in_ready=0, busy=1.
  - After rstn rises, the block blanks the screen before accepting any input.
- Output timing:
  - in_ready = (state==IDLE), decoded combinationally from the state register.
  - wr_en, wr_addr and wr_data are registered.
- Address arithmetic:
  - row_base register holds cur_y*COLS; no multiplier.
  - Line advance: row_base += COLS; on wrap from ROWS-1, row_base=0 and cur_y=0.
- States:
  - IDLE: in_ready=1, wr_en=0. An accepted byte at edge T is decoded as below.
  - WRITE: one cycle. wr_en=1, wr_addr=row_base+cur_x, wr_data=byte; these values are visible in cycle T+1. Then:
    - if cur_x < COLS-1: cur_x+1, back to IDLE;
    - if cur_x == COLS-1: line advance and cur_x=0, then CLR_LINE.
  - CLR_LINE: exactly COLS cycles with wr_en=1, wr_data=FILL, wr_addr=row_base+k for k=0..COLS-1 (row_base of the new row). Then IDLE.
  - CLR_ALL: exactly COLS*ROWS cycles with wr_en=1, wr_data=FILL, wr_addr=0..COLS*ROWS-1 ascending. Then cursor=(0,0), row_base=0, IDLE.
- Decode of a byte accepted in IDLE:
  - 0x0A LF: cur_x=0, line advance, then CLR_LINE.
  - 0x0D CR: cur_x=0, no write, stay IDLE.
  - 0x08 BS:
    - if cur_x>0: cur_x-1, then WRITE with data FILL at the new cur_x, and the cursor is not re-advanced.
    - if cur_x==0: no effect.
  - 0x0C FF: CLR_ALL.
  - Other 0x00..0x1F and 0x7F: dropped, no write, no cursor change.
  - 0x20..0x7E and 0x80..0xFF: WRITE.
- Throughput: 2 cycles per printable byte. in_ready is low during the WRITE cycle.
- Boundaries:
  - Wrap from row ROWS-1 goes to row 0 (no scroll); row 0 is cleared by CLR_LINE.
  - A printable byte at (COLS-1, ROWS-1) writes address COLS*ROWS-1, moves the cursor to (0,0) and clears addresses 0..COLS-1.
  - in_valid held high while busy: the byte is not consumed; in_data must stay stable until accepted.
  - rstn asserted mid-clear or mid-write: wr_en drops immediately and the full CLR_ALL restarts after release.
- Invariant: wr_addr < COLS*ROWS whenever wr_en=1.

Decomposition:
- Shared package/header holds:
  - control-code constants: CH_LF, CH_CR, CH_BS, CH_FF, CH_SPACE;
  - state encoding localparams: IDLE, WRITE, CLR_LINE, CLR_ALL;
  - default COLS/ROWS shared with tileram and top.
- No sub-module. One FSM with a shared clear counter (log2(COLS*ROWS) bits) reused by CLR_LINE and CLR_ALL. Expected size about 150-200 lines.

Test Plan:
- Release rstn, in_valid=0 -> 1200 consecutive wr_en cycles, addr 0..1199, data 0x20, busy=1 throughout; then in_ready=1, cursor (0,0).
- After init, send 0x41 -> the next cycle shows wr_en=1, addr=0, data=0x41, in_ready=0; then cur_x=1 and in_ready=1.
- Send 40 x 0x42 from (0,0) -> writes to addr 0..39, then 40 writes of 0x20 to addr 40..79, cursor ends (0,1).
- Cursor (5,29), send 0x0A -> 40 writes of 0x20 to addr 0..39, cursor (0,0); then send 0x08 -> no write, cursor unchanged.
- Cursor (3,2), send 0x08 -> single write addr 82 data 0x20, cursor (2,2); then send 0x0D -> cursor (0,2), no write; then send 0x07 -> dropped.
- Send 0x0C, assert rstn low at clear cycle 500, hold 3 cycles -> wr_en=0 asynchronously; after release a fresh 1200-cycle clear runs from addr 0.
